// File: rtl/fp_pkg.sv
// Shared floating-point operand class encoding for the classifier and the FP datapath.
package fp_pkg;

  typedef enum logic [2:0] {
    FP_ZERO = 3'd0,
    FP_SUB  = 3'd1,
    FP_NORM = 3'd2,
    FP_INF  = 3'd3,
    FP_QNAN = 3'd4,
    FP_SNAN = 3'd5
  } fp_class_t;

  localparam int FP_NUM_CLASSES = 6;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 operand decode: {sign, exponent, mantissa} -> fp_class_t.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [EXP_W+MAN_W:0] word,
  output fp_class_t            cls,
  output logic                 sign
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign exp_f = word[MAN_W +: EXP_W];
  assign man_f = word[MAN_W-1:0];
  assign sign  = word[EXP_W+MAN_W];

  // The mantissa MSB is the quiet bit; it only matters when the exponent is all-ones.
  always_comb begin
    cls = FP_NORM;
    if (exp_f == '0) begin
      cls = (man_f == '0) ? FP_ZERO : FP_SUB;
    end else if (exp_f == '1) begin
      if (man_f == '0)
        cls = FP_INF;
      else if (man_f[MAN_W-1])
        cls = FP_QNAN;
      else
        cls = FP_SNAN;
    end
  end

endmodule

// File: rtl/fp_classify_stream.sv
// Streaming operand classifier: one registered output stage with backpressure and
// saturating per-class counters updated at input acceptance.
module fp_classify_stream
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int CNT_W = 16
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [EXP_W+MAN_W:0]                      in_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output fp_class_t                                 out_class,
  output logic                                      out_sign,
  output logic [EXP_W+MAN_W:0]                      out_data,
  input  logic                                      clear_counts,
  output logic [FP_NUM_CLASSES-1:0][CNT_W-1:0]      counts
);

  fp_class_t                 in_class;
  logic                      in_sign;
  logic                      accept;
  logic [FP_NUM_CLASSES-1:0] hit;

  fp_classify #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_classify (
    .word (in_data),
    .cls  (in_class),
    .sign (in_sign)
  );

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_class <= FP_ZERO;
      out_sign  <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_class <= in_class;
      out_sign  <= in_sign;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_comb begin
    hit = '0;
    if (accept)
      hit[in_class] = 1'b1;
  end

  // Clear takes effect before the same-cycle increment, so a cleared hit lands at 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      counts <= '0;
    end else begin
      for (int unsigned c = 0; c < FP_NUM_CLASSES; c++) begin
        if (clear_counts)
          counts[c] <= CNT_W'(hit[c]);
        else if (hit[c] && (counts[c] != '1))
          counts[c] <= counts[c] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp_classify_stream.sv
// Self-checking bench for fp_classify_stream: binary16 reference model plus directed
// checks on a saturating (CNT_W=4) and a binary32 instance.
module tb_fp_classify_stream;
  import fp_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  // binary16, CNT_W=16 instance (model-checked)
  logic             in_valid, in_ready, out_valid, out_ready, out_sign, clear_counts;
  logic [15:0]      in_data, out_data;
  fp_class_t        out_class;
  logic [5:0][15:0] counts;

  // binary16, CNT_W=4 instance (saturation)
  logic             s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_sign, s_clear;
  logic [15:0]      s_in_data, s_out_data;
  fp_class_t        s_out_class;
  logic [5:0][3:0]  s_counts;

  // binary32 instance
  logic             w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_sign, w_clear;
  logic [31:0]      w_in_data, w_out_data;
  fp_class_t        w_out_class;
  logic [5:0][15:0] w_counts;

  fp_classify_stream #(.EXP_W(5), .MAN_W(10), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_sign(out_sign), .out_data(out_data),
    .clear_counts(clear_counts), .counts(counts)
  );

  fp_classify_stream #(.EXP_W(5), .MAN_W(10), .CNT_W(4)) u_sat (
    .clock(clock), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_class(s_out_class), .out_sign(s_out_sign), .out_data(s_out_data),
    .clear_counts(s_clear), .counts(s_counts)
  );

  fp_classify_stream #(.EXP_W(8), .MAN_W(23), .CNT_W(16)) u_wide (
    .clock(clock), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_data(w_in_data), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_class(w_out_class), .out_sign(w_out_sign), .out_data(w_out_data),
    .clear_counts(w_clear), .counts(w_counts)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Class of a binary16 word straight from the field rules.
  function automatic fp_class_t ref_class16(input logic [15:0] w);
    int e = int'(w[14:10]);
    int m = int'(w[9:0]);
    if (e == 0)  return (m == 0) ? FP_ZERO : FP_SUB;
    if (e == 31) begin
      if (m == 0)   return FP_INF;
      if (m >= 512) return FP_QNAN;
      return FP_SNAN;
    end
    return FP_NORM;
  endfunction

  // Reference model: one held slot plus saturating class tallies.
  bit          m_on = 1'b0;
  bit          m_valid;
  logic [15:0] m_data;
  int          m_cnt[6];

  always @(posedge clock) begin
    bit acc;
    if (reset) begin
      m_on    = 1'b1;
      m_valid = 1'b0;
      m_data  = '0;
      foreach (m_cnt[k]) m_cnt[k] = 0;
    end else if (m_on) begin
      acc = in_valid && (!m_valid || out_ready);
      if (clear_counts) foreach (m_cnt[k]) m_cnt[k] = 0;
      if (acc) begin
        if (m_cnt[int'(ref_class16(in_data))] < 65535)
          m_cnt[int'(ref_class16(in_data))]++;
        m_valid = 1'b1;
        m_data  = in_data;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (m_on) begin
      check("in_ready", in_ready, (!m_valid || out_ready));
      check("out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("out_data", out_data, m_data);
        check("out_sign", out_sign, m_data[15]);
        check("out_class", out_class, ref_class16(m_data));
      end
      for (int c = 0; c < 6; c++)
        check($sformatf("counts[%0d]", c), counts[c], m_cnt[c]);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "time limit");
  end

  logic [15:0] dir_w[8]   = '{16'h0000, 16'h8000, 16'h0001, 16'h3C00,
                              16'h7C00, 16'hFC00, 16'h7E00, 16'h7C01};
  fp_class_t   dir_c[8]   = '{FP_ZERO, FP_ZERO, FP_SUB, FP_NORM,
                              FP_INF, FP_INF, FP_QNAN, FP_SNAN};
  logic        dir_s[8]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  int          ex_cnt[6]  = '{2, 2046, 61440, 2, 1024, 1022};

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clear_counts = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1; s_clear = 1'b0;
    w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b1; w_clear = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    @(negedge clock);
    check("rst out_valid", out_valid, 1'b0);
    check("rst in_ready", in_ready, 1'b1);
    check("rst out_class", out_class, FP_ZERO);
    check("rst out_data", out_data, 16'h0000);
    check("rst counts", counts, '0);

    // Directed binary16 vectors, each visible one cycle after acceptance.
    for (int i = 0; i < 8; i++) begin
      in_data  = dir_w[i];
      in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
      @(negedge clock);
      check($sformatf("dir%0d valid", i), out_valid, 1'b1);
      check($sformatf("dir%0d class", i), out_class, dir_c[i]);
      check($sformatf("dir%0d sign", i), out_sign, dir_s[i]);
    end

    // Saturation on the CNT_W=4 instance.
    s_in_data  = 16'h0001;
    s_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    s_in_valid = 1'b0;
    @(negedge clock);
    for (int c = 0; c < 6; c++)
      check($sformatf("sat counts[%0d]", c), s_counts[c], (c == 1) ? 4'd15 : 4'd0);

    // Exhaustive stream; clear coincides with accepting word 0.
    @(posedge clock); #1;
    for (int i = 0; i < 65536; i++) begin
      in_data      = 16'(i);
      in_valid     = 1'b1;
      clear_counts = (i == 0);
      tick();
    end
    in_valid     = 1'b0;
    clear_counts = 1'b0;
    @(negedge clock);
    for (int c = 0; c < 6; c++)
      check($sformatf("exh counts[%0d]", c), counts[c], ex_cnt[c]);
    check("exh last data", out_data, 16'hFFFF);

    // Random backpressure; model tracks loss, duplication and stall stability.
    tick();
    for (int i = 0; i < 600; i++) begin
      in_valid  = $urandom_range(0, 1);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 99) < 60);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();

    // Clear with same-cycle accept.
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data  = 16'h3C00 + 16'(i);
      in_valid = 1'b1;
      tick();
    end
    in_data      = 16'h0001;
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    in_valid     = 1'b0;
    @(negedge clock);
    for (int c = 0; c < 6; c++)
      check($sformatf("clr counts[%0d]", c), counts[c], (c == 1) ? 16'd1 : 16'd0);

    // binary32 directed vectors.
    @(posedge clock); #1;
    w_in_data  = 32'h7FC00000;
    w_in_valid = 1'b1;
    @(posedge clock);
    #1 w_in_data = 32'h00000001;
    @(negedge clock);
    check("w32 qnan class", w_out_class, FP_QNAN);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("w32 sub class", w_out_class, FP_SUB);
    check("w32 sub data", w_out_data, 32'h00000001);

    // Reset during a stall on both the binary16 and binary32 instances.
    in_data     = 16'h7E00;
    in_valid    = 1'b1;
    w_in_data   = 32'h3F800000;
    tick();
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    w_in_valid  = 1'b1;
    w_in_data   = 32'hFF800000;
    w_out_ready = 1'b0;
    tick();
    tick();
    @(negedge clock);
    check("stall out_valid", out_valid, 1'b1);
    check("stall in_ready", in_ready, 1'b0);
    check("stall out_data", out_data, 16'h7E00);
    check("w32 stall data", w_out_data, 32'h3F800000);
    check("w32 stall class", w_out_class, FP_NORM);
    @(posedge clock); #1;
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    w_in_valid = 1'b0;
    @(negedge clock);
    check("rst2 out_valid", out_valid, 1'b0);
    check("rst2 in_ready", in_ready, 1'b1);
    check("rst2 counts", counts, '0);
    check("w32 rst out_valid", w_out_valid, 1'b0);
    check("w32 rst in_ready", w_in_ready, 1'b1);
    check("w32 rst counts", w_counts, '0);
    check("w32 rst data", w_out_data, 32'h0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
